// File: rtl/bcd_clock_core_if.sv
// Bundle of pulse inputs, time registers and display outputs for bcd_clock_core.
// Optional alarm signals appear when BCD_CLOCK_ALARM_EN is defined.
interface bcd_clock_core_if;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic       disp_sel;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic       pm;
  logic [3:0] dig3;
  logic [3:0] dig2;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic [3:0] blank;
`ifdef BCD_CLOCK_ALARM_EN
  logic [2:0] state;
  logic       alarm_on;
  logic       alarm;

  modport master (
    output tick, btn_mode, btn_inc, disp_sel, alarm_on,
    input  hour, min, sec, pm, dig3, dig2, dig1, dig0, blank, state, alarm
  );
  modport slave (
    input  tick, btn_mode, btn_inc, disp_sel, alarm_on,
    output hour, min, sec, pm, dig3, dig2, dig1, dig0, blank, state, alarm
  );
`else
  logic [1:0] state;

  modport master (
    output tick, btn_mode, btn_inc, disp_sel,
    input  hour, min, sec, pm, dig3, dig2, dig1, dig0, blank, state
  );
  modport slave (
    input  tick, btn_mode, btn_inc, disp_sel,
    output hour, min, sec, pm, dig3, dig2, dig1, dig0, blank, state
  );
`endif
endinterface

// File: rtl/bcd_clock_core.sv
// Settable HH:MM:SS BCD time-of-day core, 12/24-hour mode, button-driven
// time-set FSM and blink-masked 4-digit display outputs.
// Optional alarm (extra set states, alarm_on/alarm) with BCD_CLOCK_ALARM_EN.
//
// state  | meaning
// RUN    | clock advances on tick, view chosen by disp_sel
// SET_H  | clock paused, btn_inc edits hour
// SET_M  | clock paused, btn_inc edits minutes
// SET_S  | clock paused, btn_inc edits seconds
// SET_AH | (alarm build) btn_inc edits alarm hour
// SET_AM | (alarm build) btn_inc edits alarm minutes
module bcd_clock_core #(
  parameter int H24     = 1,
  parameter int BLINK_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  bcd_clock_core_if.slave  bus
);

`ifdef BCD_CLOCK_ALARM_EN
  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    SET_AH = 3'd4,
    SET_AM = 3'd5
  } state_t;
`else
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;
`endif

  localparam logic [7:0] HOUR_RST = (H24 != 0) ? 8'h00 : 8'h12;

  state_t               state_q;
  logic [7:0]           hour_q;
  logic [7:0]           min_q;
  logic [7:0]           sec_q;
  logic                 pm_q;
  logic [BLINK_W-1:0]   blink_q;
  logic [15:0]          disp;
  logic [3:0]           blank_d;
  logic [7:0]           view_h;
  logic [7:0]           view_m;
  logic                 mmss;
`ifdef BCD_CLOCK_ALARM_EN
  logic [7:0]           al_hour_q;
  logic [7:0]           al_min_q;
  logic                 al_pm_q;
`endif

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc60(input logic [7:0] v);
    return (v >= 8'h59) ? 8'h00 : bcd_inc(v);
  endfunction

  // Returns {pm, hour}. 12-hour mode: 11->12 flips pm, 12->01 keeps it.
  function automatic logic [8:0] inc_hour(input logic [7:0] h, input logic p);
    if (H24 != 0)       return {1'b0, (h >= 8'h23) ? 8'h00 : bcd_inc(h)};
    else if (h == 8'h11) return {~p, 8'h12};
    else if (h >= 8'h12) return {p, 8'h01};
    else                 return {p, bcd_inc(h)};
  endfunction

  // Free-running blink counter; its MSB is the blink phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= '0;
    else        blink_q <= blink_q + {{(BLINK_W-1){1'b0}}, 1'b1};
  end

  // Set-mode FSM plus time (and alarm) registers; mode pulse beats inc pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      hour_q    <= HOUR_RST;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      pm_q      <= 1'b0;
`ifdef BCD_CLOCK_ALARM_EN
      al_hour_q <= HOUR_RST;
      al_min_q  <= 8'h00;
      al_pm_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (bus.tick) begin
            sec_q <= inc60(sec_q);
            if (sec_q == 8'h59) begin
              min_q <= inc60(min_q);
              if (min_q == 8'h59) {pm_q, hour_q} <= inc_hour(hour_q, pm_q);
            end
          end
          if (bus.btn_mode) state_q <= SET_H;
        end
        SET_H: begin
          if (bus.btn_mode)     state_q <= SET_M;
          else if (bus.btn_inc) {pm_q, hour_q} <= inc_hour(hour_q, pm_q);
        end
        SET_M: begin
          if (bus.btn_mode)     state_q <= SET_S;
          else if (bus.btn_inc) min_q <= inc60(min_q);
        end
        SET_S: begin
`ifdef BCD_CLOCK_ALARM_EN
          if (bus.btn_mode)     state_q <= SET_AH;
`else
          if (bus.btn_mode)     state_q <= RUN;
`endif
          else if (bus.btn_inc) sec_q <= inc60(sec_q);
        end
`ifdef BCD_CLOCK_ALARM_EN
        SET_AH: begin
          if (bus.btn_mode)     state_q <= SET_AM;
          else if (bus.btn_inc) {al_pm_q, al_hour_q} <= inc_hour(al_hour_q, al_pm_q);
        end
        SET_AM: begin
          if (bus.btn_mode)     state_q <= RUN;
          else if (bus.btn_inc) al_min_q <= inc60(al_min_q);
        end
`endif
        default: state_q <= RUN;
      endcase
    end
  end

  // Digit selection and blink mask, straight from registers (no added latency).
  always_comb begin
    mmss    = 1'b0;
    blank_d = 4'b0000;
    view_h  = hour_q;
    view_m  = min_q;
    case (state_q)
      RUN:     mmss = bus.disp_sel;
      SET_S:   mmss = 1'b1;
`ifdef BCD_CLOCK_ALARM_EN
      SET_AH,
      SET_AM: begin
        view_h = al_hour_q;
        view_m = al_min_q;
      end
`endif
      default: mmss = 1'b0;
    endcase
    if (blink_q[BLINK_W-1]) begin
      case (state_q)
        SET_H:   blank_d = 4'b1100;
        SET_M,
        SET_S:   blank_d = 4'b0011;
`ifdef BCD_CLOCK_ALARM_EN
        SET_AH:  blank_d = 4'b1100;
        SET_AM:  blank_d = 4'b0011;
`endif
        default: blank_d = 4'b0000;
      endcase
    end
    disp = mmss ? {min_q, sec_q} : {view_h, view_m};
  end

  assign bus.hour  = hour_q;
  assign bus.min   = min_q;
  assign bus.sec   = sec_q;
  assign bus.pm    = pm_q;
  assign bus.state = state_q;
  assign bus.dig3  = disp[15:12];
  assign bus.dig2  = disp[11:8];
  assign bus.dig1  = disp[7:4];
  assign bus.dig0  = disp[3:0];
  assign bus.blank = blank_d;

`ifdef BCD_CLOCK_ALARM_EN
  assign bus.alarm = bus.alarm_on & (state_q == RUN) & (hour_q == al_hour_q) &
                     (min_q == al_min_q) & (pm_q == al_pm_q);
`endif

endmodule

// File: doc/bcd_clock_core.md
Name: bcd_clock_core

Overview:
- Settable HH:MM:SS BCD time-of-day core with a selectable 12/24-hour mode, a button-driven time-set state machine and blink-masked digit outputs.
- Advances on a one-cycle 1 Hz enable.
- Drives four BCD digits plus a per-digit blank mask into the 4-digit scan/7-segment path.
- Replaces the fixed 24-hour counter and hour/minute vs minute/second selector pair.

Parameters:
- H24, 1: 1 = 24-hour count (00..23); 0 = 12-hour count (01..12) with pm flag.
- BLINK_W, 24: width of the free-running blink counter; blink phase = counter MSB.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- tick  input  1  one-cycle pulse, 1 Hz time base
- btn_mode  input  1  one-cycle pulse, pre-debounced; advances set state
- btn_inc  input  1  one-cycle pulse, pre-debounced; increments field being set
- disp_sel  input  1  0 = HH:MM view, 1 = MM:SS view (RUN only)
- hour  output  8  BCD hour {tens,ones}
- min  output  8  BCD minutes
- sec  output  8  BCD seconds
- pm  output  1  PM flag; always 0 when H24=1
- dig3,dig2,dig1,dig0  output  4 each  BCD digits to scan (dig3 leftmost)
- blank  output  4  1 = blank digit {dig3..dig0}
- state  output  2  0 RUN, 1 SET_H, 2 SET_M, 3 SET_S

Behaviour:
- Clock and reset: single clk; reset is asynchronous and active-low (rst_n).
- Reset values:
  - H24=1: 00:00:00, pm=0.
  - H24=0: 12:00:00, pm=0.
  - state=RUN, blink counter=0, blank=0000.
- Register updates: time registers and state are registered; changes occur at the clk edge where the qualifying pulse is sampled.
- Digit outputs: dig*/blank are combinational from registers, so there is no additional latency.
- RUN, on tick:
  - sec+1; 59->00 with carry to min.
  - min 59->00 with carry to hour.
  - H24=1: hour 23->00.
  - H24=0: hour 11->12 toggles pm; 12->01 with no pm change.
  - Units digit 9->0 carries to tens digit; no non-BCD value (A..F) is ever produced.
- SET_H/SET_M/SET_S: tick is ignored and the clock is paused.
  - btn_inc increments only the selected field, wrapping with no carry.
  - sec/min wrap 59->00.
  - Hour wraps per H24 rules, including the pm toggle at 11->12 (12-hour mode cycles all 24 hour values).
- State machine, on btn_mode: RUN->SET_H->SET_M->SET_S->RUN. On SET_S->RUN the clock resumes from the set value, with no reset of seconds.
- Simultaneous pulses:
  - btn_mode with btn_inc in the same cycle: the mode transition wins and btn_inc is dropped.
  - tick with btn_mode in RUN: the tick is applied and state moves to SET_H.
- Display mapping:
  - HH:MM view: dig3=hour[7:4], dig2=hour[3:0], dig1=min[7:4], dig0=min[3:0].
  - MM:SS view: dig3=min tens, dig2=min ones, dig1=sec tens, dig0=sec ones.
  - RUN uses disp_sel.
  - SET_H and SET_M force the HH:MM view; SET_S forces the MM:SS view.
- Blank mask:
  - Blink counter runs freely in all states.
  - When its MSB=1 in a SET state, the two digits of the edited field are blanked: SET_H blank=1100, SET_M blank=0011, SET_S blank=0011.
  - Otherwise blank=0000.
- Reset mid-operation: any state returns immediately to the reset values and RUN; an edit in progress is discarded.

Optional Feature:
- Macro: BCD_CLOCK_ALARM_EN.
- With the macro defined:
  - Adds ports alarm_on (input 1) and alarm (output 1).
  - Adds states SET_AH and SET_AM after SET_S; the state port widens to 3 bits with codes 4 and 5. Sequence becomes SET_S->SET_AH->SET_AM->RUN.
  - Alarm hour/min registers reset to the same value as the time. They are edited with btn_inc using the same wrap rules, displayed in HH:MM view and blink-masked like SET_H/SET_M.
  - alarm = alarm_on & (state==RUN) & (hour,min,pm equal the alarm registers), i.e. high for the whole matching minute.
- Without the macro: no alarm ports, registers or states, and the state port is 2 bits.

Test Plan:
- H24=1, preload 23:59:59 via set mode, one tick -> 00:00:00, pm=0.
- H24=0: 11:59:59 pm=0 + tick -> 12:00:00 pm=1; 12:59:59 + tick -> 01:00:00 pm=1; reset -> 12:00:00 pm=0.
- Set sequence:
  - btn_mode, then 5x btn_inc -> hour=05 (H24=1), state=1.
  - btn_mode, then 61x btn_inc -> min=01 with hour still 05.
  - In SET states, 10 ticks leave sec unchanged.
- Same-cycle btn_mode+btn_inc in SET_H -> state=SET_M, hour unchanged.
- Same-cycle tick+btn_mode at 00:00:09 -> sec=10, state=SET_H.
- Blink and reset:
  - BLINK_W=4, SET_M -> blank toggles 0000/0011 every 8 clk.
  - rst_n low mid-SET_M -> state=RUN, time=reset value, blank=0000 without waiting for a clk edge.
- BCD_CLOCK_ALARM_EN: alarm set 07:30 with alarm_on=1, time 07:29:59 + tick -> alarm=1.
  - alarm stays high through 07:30:59 and drops at 07:31:00.
  - alarm_on=0 -> alarm=0.
